// File: rtl/ysyx_22041412_mem_pkg.sv
// Shared types and helpers for the data-cache burst memory responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ysyx_22041412_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_LAT,
        W_BURST,
        R_LAT,
        R_BURST,
        DONE
    } state_e;

    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;
    localparam logic [2:0] SZ_D = 3'b011;

    // Byte-lane mask for a single-beat access of the given size starting at
    // lane off. Lanes pushed past 7 fall off the top of the 8-bit result.
    function automatic logic [7:0] size_to_mask(input logic [2:0] size,
                                                input logic [2:0] off);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            SZ_D:    m = 8'hFF;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/ysyx_22041412_sram_1rw.sv
// Single-port 64-bit SRAM with per-byte write enables.
// Latency: read data appears one cycle after i_en && !i_we; writes land at that edge.
// Backpressure: none; accepts one access every cycle.
// Ports: clk, i_rst_n (clears only the read-data register), i_en, i_we,
//        i_addr, i_wdata, i_be, o_rdata (holds the last read value).
module ysyx_22041412_sram_1rw
    import ysyx_22041412_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [63:0]           i_wdata,
    input  logic [7:0]            i_be,
    output logic [63:0]           o_rdata
);

    logic [63:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [63:0] r_rdata;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Output register only updates on reads, so it holds the last beat.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_22041412_axi_mem_resp.sv
// Burst memory responder for Dcache refill (read) and writeback (write) bursts.
// Latency: request accepted at edge T, beat k strobes in cycle T+LATENCY+1+k.
// Backpressure: none; one beat per cycle once the burst starts, single outstanding.
// Ports: clk, rst (async active-low); read channel r_valid_i/r_addr_i/r_len_i in,
//        r_ready_o/r_last_o/r_data_o out; write channel w_valid_i/w_addr_i/w_len_i/
//        w_size_i/w_data_i in, w_ready_o/w_last_o out.
module ysyx_22041412_axi_mem_resp
    import ysyx_22041412_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DEPTH_LOG2 = 12,
    parameter int                    LATENCY    = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r_valid_i,
    input  logic [ADDR_WIDTH-1:0] r_addr_i,
    input  logic [7:0]            r_len_i,
    output logic                  r_ready_o,
    output logic                  r_last_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    input  logic                  w_valid_i,
    input  logic [ADDR_WIDTH-1:0] w_addr_i,
    input  logic [7:0]            w_len_i,
    input  logic [2:0]            w_size_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    output logic                  w_ready_o,
    output logic                  w_last_o
);

    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [2:0]              r_size;
    logic                    r_is_wr;
    logic [7:0]              r_beat;
    logic [LW-1:0]           r_lat_cnt;

    logic                    r_rd_vld;
    logic                    r_rd_last;
    logic                    r_wr_vld;
    logic                    r_wr_last;
    logic [DEPTH_LOG2-1:0]   r_wr_idx;
    logic [7:0]              r_wr_be;

    logic                    w_cap_w;
    logic                    w_cap_r;
    logic                    w_lat_done;
    logic                    w_beat_last;
    logic                    w_in_lat;
    logic                    w_in_burst;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [7:0]              w_be;
    logic                    w_sram_en;
    logic [DEPTH_LOG2-1:0]   w_sram_addr;
    logic [63:0]             w_sram_rdata;

    assign w_lat_done  = (r_lat_cnt == LW'(LATENCY - 1));
    assign w_beat_last = (r_beat == r_len);
    assign w_in_lat    = (r_state == W_LAT) || (r_state == R_LAT);
    assign w_in_burst  = (r_state == W_BURST) || (r_state == R_BURST);

    // Word index wraps naturally by truncation to DEPTH_LOG2 bits.
    assign w_idx = DEPTH_LOG2'((r_addr - BASE_ADDR) >> 3) + DEPTH_LOG2'(r_beat);

    // Only single-beat writes are narrowed by size; burst beats are full lines.
    assign w_be = (r_len == 8'd0) ? size_to_mask(r_size, r_addr[2:0]) : 8'hFF;

    always_comb begin
        w_state_nxt = r_state;
        w_cap_w     = 1'b0;
        w_cap_r     = 1'b0;
        case (r_state)
            IDLE: begin
                // Write has priority so a writeback lands before the refill.
                if (w_valid_i) begin
                    w_state_nxt = W_LAT;
                    w_cap_w     = 1'b1;
                end else if (r_valid_i) begin
                    w_state_nxt = R_LAT;
                    w_cap_r     = 1'b1;
                end
            end
            W_LAT:   if (w_lat_done)  w_state_nxt = W_BURST;
            R_LAT:   if (w_lat_done)  w_state_nxt = R_BURST;
            W_BURST: if (w_beat_last) w_state_nxt = DONE;
            R_BURST: if (w_beat_last) w_state_nxt = DONE;
            DONE: begin
                // Wait for the initiator to drop valid so a held request
                // is not served twice.
                if (!(r_is_wr ? w_valid_i : r_valid_i)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_is_wr   <= 1'b0;
            r_beat    <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (w_cap_w) begin
                r_addr  <= w_addr_i;
                r_len   <= w_len_i;
                r_size  <= w_size_i;
                r_is_wr <= 1'b1;
            end else if (w_cap_r) begin
                r_addr  <= r_addr_i;
                r_len   <= r_len_i;
                r_is_wr <= 1'b0;
            end

            if (w_in_lat && !w_lat_done) begin
                r_lat_cnt <= r_lat_cnt + LW'(1);
            end else begin
                r_lat_cnt <= '0;
            end

            if (w_in_burst) begin
                r_beat <= r_beat + 8'd1;
            end else begin
                r_beat <= '0;
            end
        end
    end

    // Beat strobes trail the burst state by one cycle: that cycle covers the
    // SRAM read latency on reads, and on writes it presents the registered
    // index/mask so the beat lands at the edge ending the w_ready_o cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_wr_last <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_be   <= '0;
        end else begin
            r_rd_vld  <= (r_state == R_BURST);
            r_rd_last <= (r_state == R_BURST) && w_beat_last;
            r_wr_vld  <= (r_state == W_BURST);
            r_wr_last <= (r_state == W_BURST) && w_beat_last;
            r_wr_idx  <= w_idx;
            r_wr_be   <= w_be;
        end
    end

    assign w_sram_en   = (r_state == R_BURST) || r_wr_vld;
    assign w_sram_addr = r_wr_vld ? r_wr_idx : w_idx;

    ysyx_22041412_sram_1rw #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk     (clk),
        .i_rst_n (rst),
        .i_en    (w_sram_en),
        .i_we    (r_wr_vld),
        .i_addr  (w_sram_addr),
        .i_wdata (w_data_i),
        .i_be    (r_wr_be),
        .o_rdata (w_sram_rdata)
    );

    assign r_ready_o = r_rd_vld;
    assign r_last_o  = r_rd_last;
    assign r_data_o  = w_sram_rdata;
    assign w_ready_o = r_wr_vld;
    assign w_last_o  = r_wr_last;

endmodule

// File: tb/tb_ysyx_22041412_axi_mem_resp.sv
// Self-checking bench for the burst memory responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_ysyx_22041412_axi_mem_resp;

    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        r_valid_i;
    logic [31:0] r_addr_i;
    logic [7:0]  r_len_i;
    logic        r_ready_o;
    logic        r_last_o;
    logic [63:0] r_data_o;
    logic        w_valid_i;
    logic [31:0] w_addr_i;
    logic [7:0]  w_len_i;
    logic [2:0]  w_size_i;
    logic [63:0] w_data_i;
    logic        w_ready_o;
    logic        w_last_o;

    int n_chk;
    int n_pass;

    logic [63:0] mdl   [0:4095];
    logic [63:0] wdat  [0:255];

    ysyx_22041412_axi_mem_resp #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .DEPTH_LOG2 (12),
        .LATENCY    (LAT),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r_valid_i (r_valid_i),
        .r_addr_i  (r_addr_i),
        .r_len_i   (r_len_i),
        .r_ready_o (r_ready_o),
        .r_last_o  (r_last_o),
        .r_data_o  (r_data_o),
        .w_valid_i (w_valid_i),
        .w_addr_i  (w_addr_i),
        .w_len_i   (w_len_i),
        .w_size_i  (w_size_i),
        .w_data_i  (w_data_i),
        .w_ready_o (w_ready_o),
        .w_last_o  (w_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a, input int k);
        logic [31:0] w;
        w = ((a - BASE) >> 3) + 32'(k);
        return int'(w % 32'd4096);
    endfunction

    // Reference memory update: a single beat touches 2^size bytes from the
    // address's byte offset, clipped to the 8-byte word; burst beats replace the word.
    task automatic mdl_write(input logic [31:0] a, input int len, input logic [2:0] sz,
                             input int k, input logic [63:0] d);
        int idx;
        int nb;
        int off;
        idx = widx(a, k);
        if (len == 0) begin
            nb  = (sz >= 3'd3) ? 8 : (1 << sz);
            off = int'(a[2:0]);
            for (int b = off; b < off + nb && b < 8; b++) begin
                mdl[idx][b*8 +: 8] = d[b*8 +: 8];
            end
        end else begin
            mdl[idx] = d;
        end
    endtask

    task automatic wr_burst(input logic [31:0] a, input int len, input logic [2:0] sz,
                            input bit also_rd, input logic [31:0] ra, input int rlen);
        int k;
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        w_addr_i  = a;
        w_len_i   = 8'(len);
        w_size_i  = sz;
        w_data_i  = wdat[0];
        w_valid_i = 1'b1;
        if (also_rd) begin
            r_addr_i  = ra;
            r_len_i   = 8'(rlen);
            r_valid_i = 1'b1;
        end
        k   = 0;
        cyc = 0;
        while (k <= len && cyc < 1000) begin
            @(negedge clk);
            if (also_rd) chk("rd_quiet_during_wr", 64'(r_ready_o), 64'd0);
            if (w_ready_o) begin
                chk("wr_beat_cyc", 64'(cyc), 64'(LAT + 2 + k));
                chk("wr_last", 64'(w_last_o), 64'(k == len));
                mdl_write(a, len, sz, k, wdat[k]);
                k++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (k <= len) w_data_i = wdat[k];
        end
        if (k <= len) chk("wr_timeout", 64'(k), 64'(len + 1));
        w_valid_i = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] a, input int len, input bit skip_setup);
        int k;
        int cyc;
        int c0;
        if (!skip_setup) begin
            repeat (2) @(posedge clk);
            #1;
            r_addr_i  = a;
            r_len_i   = 8'(len);
            r_valid_i = 1'b1;
        end
        k   = 0;
        cyc = 0;
        c0  = LAT + 2;
        while (k <= len && cyc < 1000) begin
            @(negedge clk);
            if (r_ready_o) begin
                if (skip_setup && k == 0) c0 = cyc;
                else chk("rd_beat_cyc", 64'(cyc), 64'(c0 + k));
                chk("rd_data", r_data_o, mdl[widx(a, k)]);
                chk("rd_last", 64'(r_last_o), 64'(k == len));
                k++;
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        if (k <= len) chk("rd_timeout", 64'(k), 64'(len + 1));
        r_valid_i = 1'b0;
        @(negedge clk);
        chk("rd_quiet_after", 64'(r_ready_o), 64'd0);
        chk("rd_hold", r_data_o, mdl[widx(a, len)]);
    endtask

    initial begin
        int k;
        int cyc;
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b0;
        r_valid_i = 1'b0;
        r_addr_i  = '0;
        r_len_i   = '0;
        w_valid_i = 1'b0;
        w_addr_i  = '0;
        w_len_i   = '0;
        w_size_i  = '0;
        w_data_i  = '0;
        for (int i = 0; i < 4096; i++) mdl[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_r_ready", 64'(r_ready_o), 64'd0);
        chk("rst_r_last",  64'(r_last_o),  64'd0);
        chk("rst_r_data",  r_data_o,       64'd0);
        chk("rst_w_ready", 64'(w_ready_o), 64'd0);
        chk("rst_w_last",  64'(w_last_o),  64'd0);
        rst = 1'b1;

        // Preload words 0..255 with random data.
        for (int i = 0; i < 256; i++) wdat[i] = {$urandom, $urandom};
        wr_burst(BASE, 255, 3'd3, 1'b0, '0, 0);

        // Single-beat read of a known word.
        wdat[0] = 64'h1122_3344_5566_7788;
        wr_burst(BASE, 0, 3'd3, 1'b0, '0, 0);
        rd_burst(BASE, 0, 1'b0);
        chk("single_rd_value", r_data_o, 64'h1122_3344_5566_7788);

        // Incrementing pattern burst at 0x40.
        for (int i = 0; i < 8; i++) wdat[i] = 64'h100 + 64'(i);
        wr_burst(BASE + 32'h40, 7, 3'd3, 1'b0, '0, 0);
        rd_burst(BASE + 32'h40, 7, 1'b0);
        chk("incr_last_value", r_data_o, 64'h107);

        // Halfword write at byte offset 3.
        wdat[0] = 64'h5A5A_5ABE_EF5A_BEEF;
        wr_burst(BASE + 32'h3, 0, 3'b001, 1'b0, '0, 0);
        rd_burst(BASE, 0, 1'b0);
        chk("sz_h_bytes", r_data_o[39:24], 64'hBEEF);
        chk("sz_h_word",  r_data_o,        64'h1122_33BE_EF66_7788);

        // Write and read raised together to the same line: write first.
        for (int i = 0; i < 8; i++) wdat[i] = {$urandom, $urandom};
        wr_burst(BASE + 32'h80, 7, 3'd3, 1'b1, BASE + 32'h80, 7);
        rd_burst(BASE + 32'h80, 7, 1'b1);

        // Burst starting at the top word wraps to word 0.
        for (int i = 0; i < 4; i++) wdat[i] = {$urandom, $urandom};
        wr_burst(BASE + 32'(4095 * 8), 3, 3'd3, 1'b0, '0, 0);
        rd_burst(BASE, 2, 1'b0);
        chk("wrap_word0", r_data_o, wdat[3]);
        rd_burst(BASE + 32'(4095 * 8), 3, 1'b0);

        // Reset in the middle of a read burst, at beat 2.
        repeat (2) @(posedge clk);
        #1;
        r_addr_i  = BASE + 32'h40;
        r_len_i   = 8'd7;
        r_valid_i = 1'b1;
        k   = 0;
        cyc = 0;
        while (k < 3 && cyc < 100) begin
            @(negedge clk);
            if (r_ready_o) k++;
            if (k < 3) begin
                @(posedge clk);
                cyc++;
            end
        end
        chk("mid_rst_reached_beat2", 64'(k), 64'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_r_ready", 64'(r_ready_o), 64'd0);
        chk("mid_rst_r_last",  64'(r_last_o),  64'd0);
        chk("mid_rst_r_data",  r_data_o,       64'd0);
        chk("mid_rst_w_ready", 64'(w_ready_o), 64'd0);
        chk("mid_rst_w_last",  64'(w_last_o),  64'd0);
        r_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd_burst(BASE + 32'h40, 1, 1'b0);

        // Randomized mix of reads and writes inside the preloaded region.
        for (int it = 0; it < 24; it++) begin
            int          idx;
            int          len;
            logic [31:0] a;
            idx = int'($urandom_range(0, 239));
            len = int'($urandom_range(0, 15));
            a   = BASE + 32'(idx * 8);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) wdat[i] = {$urandom, $urandom};
                if (len == 0) begin
                    wr_burst(a + 32'($urandom_range(0, 7)), 0, 3'($urandom_range(0, 3)),
                             1'b0, '0, 0);
                end else begin
                    wr_burst(a, len, 3'd3, 1'b0, '0, 0);
                end
                rd_burst(a, len, 1'b0);
            end else begin
                rd_burst(a, len, 1'b0);
            end
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_22041412_axi_mem_resp.md
# ysyx_22041412_axi_mem_resp

Burst memory responder that sits on the far side of the data-cache refill/writeback port. It accepts the Dcache's simplified AXI-style read and write burst requests and returns read beats with a last flag, or consumes write beats with a last flag. It is backed by an internal byte-maskable 64-bit SRAM with a fixed programmable access latency. It serves as the NPC's simulation-side data memory and as the template for the SoC-facing bridge.

## Interface
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 64: beat width; fixed at 64.
- DEPTH_LOG2, 12: log2 of the SRAM word count.
- LATENCY, 2: cycles from request accept to the first beat; must be >= 1.
- BASE_ADDR, 32'h8000_0000: subtracted from the address before indexing.

- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- r_valid_i  in  1  read request; held high until the last beat is seen.
- r_addr_i  in  ADDR_WIDTH  read start address; 8-byte aligned.
- r_len_i  in  8  beats minus one.
- r_ready_o  out  1  read beat strobe; `r_data_o` is valid in this cycle.
- r_last_o  out  1  high together with the final read beat.
- r_data_o  out  64  read beat data.
- w_valid_i  in  1  write request; held high until the last beat is seen.
- w_addr_i  in  ADDR_WIDTH  write start address.
- w_len_i  in  8  beats minus one.
- w_size_i  in  3  single-beat size: 000 byte, 001 half, 010 word, 011 double.
- w_data_i  in  64  current write beat.
- w_ready_o  out  1  `w_data_i` is written at the edge ending this cycle.
- w_last_o  out  1  high with the final write beat.

## Operation
- FSM states: IDLE, W_LAT, W_BURST, R_LAT, R_BURST, DONE.
- IDLE:
  - If `w_valid_i` is high, capture addr/len/size and go to W_LAT.
  - Otherwise, if `r_valid_i` is high, capture addr/len and go to R_LAT.
  - When both are high in the same cycle, the write wins, so a writeback lands before the refill.
- W_LAT / R_LAT: the latency counter counts LATENCY cycles, then moves to the matching BURST state.
- R_BURST:
  - One beat per cycle; no backpressure.
  - The beat counter runs 0..len.
  - The word index is `((addr - BASE_ADDR) >> 3) + beat`, taken modulo 2^DEPTH_LOG2 (it wraps).
  - `r_last_o` is asserted when beat == len; the FSM then goes to DONE.
- W_BURST:
  - One beat per cycle; `w_last_o` is asserted when beat == len; the FSM then goes to DONE.
  - For len == 0 the write is byte-masked by `w_size_i` at lane offset `addr[2:0]`:
    - byte 0x01, half 0x03, word 0x0F, double 0xFF, each shifted left by `addr[2:0]`;
    - lanes beyond 7 are dropped.
  - For len > 0 every beat writes the full 0xFF mask and `w_size_i` is ignored.
- DONE:
  - Waits until the requesting valid is low, then returns to IDLE.
  - This prevents a held valid from re-triggering the same request.
- The engine is single-outstanding; the other channel's valid is ignored outside IDLE.
- Reset: FSM goes to IDLE, counters clear, all outputs are 0. SRAM contents are not reset.

## Timing
- Request accepted at edge T (in IDLE):
  - First beat strobe in cycle T+LATENCY+1.
  - Beat k strobes in cycle T+LATENCY+1+k.
- `r_ready_o`, `r_last_o` and `r_data_o` are registered. `r_data_o` holds the last beat value while idle.
- `w_ready_o` and `w_last_o` are registered. The initiator advances `w_data_i` on the edge where it sees `w_ready_o`.
- Minimum gap between two requests: 1 idle cycle after DONE.
- Asserting reset mid-burst:
  - All outputs drop to 0 asynchronously.
  - A partially written burst keeps the beats already written.

## Structure
- Shared package `ysyx_22041412_mem_pkg` holds:
  - the FSM state enum;
  - the size encodings (SZ_B/SZ_H/SZ_W/SZ_D);
  - the size-to-byte-mask function.
- Sub-module `ysyx_22041412_sram_1rw`: synchronous 1-read/1-write SRAM with 64-bit data and an 8-bit byte enable, DEPTH_LOG2 deep, 1-cycle read.
  - The responder issues the read address one cycle before each beat to absorb this read latency.

## Test plan
- Preload word 0x8000_0000 = 0x1122334455667788, then issue a read at that address with len 0 and LATENCY 2. Required: a single `r_ready_o` pulse with `r_last_o` high in cycle T+3, carrying that data; FSM returns to IDLE once valid drops.
- Read burst at 0x8000_0040 with len 7 over a preloaded incrementing pattern. Required: 8 consecutive strobes with data n..n+7, and `r_last_o` only on the 8th beat.
- Write at 0x8000_0003, size 001, data 0x...BEEF (len 0). Required: bytes 3 and 4 become EF and BE, all other bytes are unchanged on readback.
- `r_valid_i` and `w_valid_i` asserted in the same cycle to the same line. Required: the write burst completes first, then the read returns the newly written data.
- Read burst starting at the top word index with len 3. Required: the index wraps to word 0 for the remaining beats.
- Reset asserted at beat 2 of a len 7 read. Required: outputs are 0 immediately, the FSM is in IDLE, and a fresh request afterwards completes normally.
